// File: rtl/simple0_stim_seq.sv
// Stimulus sequencer and response capture for the simple0 gate cloud.
// Run length is 16*HOLD cycles from an accepted start. done and pass land on the final sample edge.
// start is only looked at in IDLE. There is no queuing, and no downstream backpressure exists.
module simple0_stim_seq #(
  parameter int unsigned HOLD   = 4,            // cycles per vector, legal 2..255
  parameter logic [31:0] EXPECT = 32'hAFAFAFCC  // golden response word
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        o1,
  input  logic        o2,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [31:0] resp,
  output logic        pass
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Last count value of a hold window; the sample is taken on this edge.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t      state;
  logic [3:0]  vec;
  logic [7:0]  cnt;
  logic [31:0] resp_next;

  // The response word with the current vector's sample merged in.
  // pass is judged on this word, so the last sample counts toward it.
  always_comb begin
    resp_next = resp;
    resp_next[{vec, 1'b0} +: 2] = {o2, o1};
  end

  // Sequencer FSM: step through the vectors, sample each at the end of its hold window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      vec   <= 4'd0;
      cnt   <= 8'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      resp  <= 32'd0;
      pass  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            vec   <= 4'd0;
            cnt   <= 8'd0;
            resp  <= 32'd0;
            pass  <= 1'b0;
            busy  <= 1'b1;
            state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt < HOLD_LAST) begin
            cnt <= cnt + 8'd1;
          end else begin
            resp <= resp_next;
            cnt  <= 8'd0;
            if (vec == 4'd15) begin
              vec   <= 4'd0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (resp_next == EXPECT);
              state <= S_DONE;
            end else begin
              vec <= vec + 4'd1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The cloud inputs are the vector register itself, so they are 0 whenever no run is active.
  assign {a, b, c, d} = vec;

endmodule

// File: tb/tb_simple0_stim_seq.sv
// Randomized bench for simple0_stim_seq.
// It checks two instances, one with HOLD=4 and one with HOLD=2.
// A behavioural stand-in drives the cloud from a 16-entry truth table.
`timescale 1ns/1ps
module tb_simple0_stim_seq;

  localparam logic [31:0] GOLD = 32'hAFAFAFCC;

  logic        clk;
  logic        rst_n;
  logic        start4, start2;
  logic        o1_4, o2_4, o1_2, o2_2;
  logic        a4, b4, c4, d4, busy4, done4, pass4;
  logic        a2, b2, c2, d2, busy2, done2, pass2;
  logic [31:0] resp4, resp2;

  logic [1:0]  tbl [16];   // {o2,o1} produced by the cloud for each input vector
  logic        stuck;      // forces o1 to 0
  logic        glitch;     // scramble outputs early in every cycle
  logic [31:0] gold_v;
  int          checks;
  int          errors;

  simple0_stim_seq #(.HOLD(4)) dut_h4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .o1(o1_4), .o2(o2_4),
    .a(a4), .b(b4), .c(c4), .d(d4), .busy(busy4), .done(done4),
    .resp(resp4), .pass(pass4)
  );

  simple0_stim_seq #(.HOLD(2)) dut_h2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .o1(o1_2), .o2(o2_2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2),
    .resp(resp2), .pass(pass2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cloud stand-in: settled value at the falling edge.
  // Optional garbage just after the rising edge models a glitch that settles before the sample edge.
  always @(negedge clk) begin
    o1_4 = tbl[{a4, b4, c4, d4}][0] & ~stuck;
    o2_4 = tbl[{a4, b4, c4, d4}][1];
    o1_2 = tbl[{a2, b2, c2, d2}][0] & ~stuck;
    o2_2 = tbl[{a2, b2, c2, d2}][1];
  end

  always @(posedge clk) begin
    #1;
    if (glitch) begin
      o1_4 = 1'($urandom);
      o2_4 = 1'($urandom);
      o1_2 = 1'($urandom);
      o2_2 = 1'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic val);
    if (sel) start2 = val;
    else     start4 = val;
  endtask

  task automatic snap(input bit sel, output logic [3:0] v, output logic bz,
                      output logic dn, output logic [31:0] rs, output logic ps);
    v  = sel ? {a2, b2, c2, d2} : {a4, b4, c4, d4};
    bz = sel ? busy2 : busy4;
    dn = sel ? done2 : done4;
    rs = sel ? resp2 : resp4;
    ps = sel ? pass2 : pass4;
  endtask

  task automatic load_gold();
    gold_v = GOLD;
    for (int i = 0; i < 16; i++) tbl[i] = gold_v[2*i +: 2];
  endtask

  task automatic load_rand();
    for (int i = 0; i < 16; i++) tbl[i] = 2'($urandom);
  endtask

  // One run from a start pulse. poke_at raises start mid-run (negative = never).
  // With keep set, start stays high from poke_at, and the bench checks that the next run is accepted two edges after done.
  task automatic run(input bit sel, input int hold, input int poke_at, input bit keep);
    logic [31:0] exp, rs;
    logic [3:0]  v;
    logic        bz, dn, ps;
    int          last;
    exp = 32'd0;
    for (int i = 0; i < 16; i++) begin
      exp[2*i+1] = tbl[i][1];
      exp[2*i]   = tbl[i][0] & ~stuck;
    end
    last = 16 * hold;
    @(negedge clk);
    set_start(sel, 1'b1);
    for (int k = 0; k <= last + (keep ? 2 : 1); k++) begin
      @(negedge clk);
      snap(sel, v, bz, dn, rs, ps);
      if (k == 0) set_start(sel, 1'b0);
      if (k == poke_at) set_start(sel, 1'b1);
      else if (k == poke_at + 1 && !keep) set_start(sel, 1'b0);
      if (k < last) begin
        chk($sformatf("busy k=%0d", k), {31'd0, bz}, 32'd1);
        chk($sformatf("done k=%0d", k), {31'd0, dn}, 32'd0);
        chk($sformatf("vec k=%0d", k), {28'd0, v}, 32'(k / hold));
        if (k == 0) begin
          chk("resp_clr", rs, 32'd0);
          chk("pass_clr", {31'd0, ps}, 32'd0);
        end
      end else if (k == last) begin
        chk("done_pulse", {31'd0, dn}, 32'd1);
        chk("busy_end", {31'd0, bz}, 32'd0);
        chk("vec_end", {28'd0, v}, 32'd0);
        chk("resp", rs, exp);
        chk("pass", {31'd0, ps}, {31'd0, exp == GOLD});
      end else if (k == last + 1) begin
        chk("done_drop", {31'd0, dn}, 32'd0);
        chk("busy_idle", {31'd0, bz}, 32'd0);
        chk("resp_hold", rs, exp);
        chk("pass_hold", {31'd0, ps}, {31'd0, exp == GOLD});
      end else begin
        chk("rerun_busy", {31'd0, bz}, 32'd1);
        chk("rerun_resp", rs, 32'd0);
        chk("rerun_pass", {31'd0, ps}, 32'd0);
        chk("rerun_vec", {28'd0, v}, 32'd0);
      end
    end
    set_start(sel, 1'b0);
  endtask

  // Reset n cycles into an ongoing run; everything clears and no done follows.
  task automatic abort_after(input bit sel, input int n);
    logic [31:0] rs;
    logic [3:0]  v;
    logic        bz, dn, ps;
    int          nd;
    for (int i = 0; i < n; i++) @(negedge clk);
    snap(sel, v, bz, dn, rs, ps);
    chk("pre_abort_busy", {31'd0, bz}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    snap(sel, v, bz, dn, rs, ps);
    chk("abort_busy", {31'd0, bz}, 32'd0);
    chk("abort_vec", {28'd0, v}, 32'd0);
    chk("abort_resp", rs, 32'd0);
    chk("abort_pass", {31'd0, ps}, 32'd0);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      snap(sel, v, bz, dn, rs, ps);
      if (dn) nd++;
    end
    chk("no_done_after_abort", 32'(nd), 32'd0);
    chk("idle_after_abort", {31'd0, bz}, 32'd0);
  endtask

  initial begin
    logic [31:0] rs;
    logic [3:0]  v;
    logic        bz, dn, ps;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start4 = 1'b0;
    start2 = 1'b0;
    stuck  = 1'b0;
    glitch = 1'b0;
    o1_4 = 1'b0; o2_4 = 1'b0; o1_2 = 1'b0; o2_2 = 1'b0;
    load_gold();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Idle state after reset, both instances.
    for (int s = 0; s < 2; s++) begin
      snap(s[0], v, bz, dn, rs, ps);
      chk($sformatf("rst_vec%0d", s), {28'd0, v}, 32'd0);
      chk($sformatf("rst_busy%0d", s), {31'd0, bz}, 32'd0);
      chk($sformatf("rst_done%0d", s), {31'd0, dn}, 32'd0);
      chk($sformatf("rst_resp%0d", s), rs, 32'd0);
      chk($sformatf("rst_pass%0d", s), {31'd0, ps}, 32'd0);
    end

    // Golden cloud, HOLD=4, with a stray start at cycle 20.
    run(1'b0, 4, 20, 1'b0);
    // Check that no second run starts from the stray start.
    repeat (3) @(negedge clk);
    chk("no_second_run", {31'd0, busy4}, 32'd0);

    // o1 stuck at 0.
    stuck = 1'b1;
    run(1'b0, 4, -5, 1'b0);
    stuck = 1'b0;

    // Random truth tables with glitching outputs.
    glitch = 1'b1;
    for (int r = 0; r < 3; r++) begin
      load_rand();
      run(1'b0, 4, -5, 1'b0);
    end
    glitch = 1'b0;

    // Start held high from cycle 20: back-to-back run, then abort it at cycle 30.
    load_gold();
    run(1'b0, 4, 20, 1'b1);
    abort_after(1'b0, 30);

    // HOLD=2 instance: golden and random tables, glitching inside each window.
    glitch = 1'b1;
    load_gold();
    run(1'b1, 2, -5, 1'b0);
    for (int r = 0; r < 2; r++) begin
      load_rand();
      run(1'b1, 2, 7, 1'b0);
    end
    stuck = 1'b1;
    load_gold();
    run(1'b1, 2, -5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
